// File: rtl/io_capture_pkg.sv
// Shared types and register-map constants for the io_pulse_capture peripheral.
package io_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StDone
    } ch_state_e;

    localparam int unsigned OffCtrl       = 0;
    localparam int unsigned OffResult0    = 1;

    localparam int unsigned StatusDoneLsb = 0;
    localparam int unsigned StatusToLsb   = 16;

endpackage

// File: rtl/capture_channel.sv
// One trigger/echo channel: pin synchronizer, edge detect, FSM, width counter, result and flags.
// Timeout logic is built only when IO_CAPTURE_TIMEOUT_EN is defined.
module capture_channel
    import io_capture_pkg::*;
#(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned TRIG_CYC    = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pin_i,
    input  logic             start_i,
    input  logic             rd_clr_i,
    output logic             trig_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] result_o
);

    // Timer is shared between the trigger pulse and the timeout window.
    localparam int unsigned TmrMax = (TRIG_CYC > TIMEOUT_CYC) ? TRIG_CYC : TIMEOUT_CYC;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    ch_state_e        state_q, state_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             to_q, to_d;

    logic pin_s, rise, fall, start_ok, trig_end, tmo;

    assign pin_s    = sync_q[1];
    assign rise     = pin_s & ~prev_q;
    assign fall     = ~pin_s & prev_q;
    assign start_ok = start_i && (state_q == StIdle || state_q == StDone);
    assign trig_end = (tmr_q == TmrW'(TRIG_CYC - 1));
`ifdef IO_CAPTURE_TIMEOUT_EN
    assign tmo      = (tmr_q == TmrW'(TIMEOUT_CYC - 1));
`else
    assign tmo      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_ok) state_d = StTrig;
            StTrig:     if (trig_end) state_d = StWaitRise;
            StWaitRise: begin
                if (tmo) state_d = StDone;
                else if (rise) state_d = StMeasure;
            end
            StMeasure:  if (fall || tmo) state_d = StDone;
            StDone:     if (start_ok) state_d = StTrig;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        trig_d = (state_d == StTrig);
        cnt_d  = cnt_q;
        tmr_d  = tmr_q;
        res_d  = res_q;
        done_d = done_q;
        to_d   = to_q;
        if (rd_clr_i) begin
            done_d = 1'b0;
            to_d   = 1'b0;
        end
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    cnt_d  = '0;
                    tmr_d  = '0;
                    done_d = 1'b0;
                    to_d   = 1'b0;
                end
            end
            StTrig: tmr_d = trig_end ? '0 : tmr_q + 1'b1;
            StWaitRise: begin
`ifdef IO_CAPTURE_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
`endif
                if (tmo) begin
                    res_d  = cnt_q;
                    done_d = 1'b1;
                    to_d   = 1'b1;
                end else if (rise) begin
                    cnt_d = CNT_W'(1);
                end
            end
            StMeasure: begin
`ifdef IO_CAPTURE_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
`endif
                if (fall) begin
                    res_d  = cnt_q;
                    done_d = 1'b1;
                end else if (tmo) begin
                    res_d  = cnt_q;
                    done_d = 1'b1;
                    to_d   = 1'b1;
                end else if (pin_s && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            trig_q <= 1'b0;
            cnt_q  <= '0;
            tmr_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            prev_q <= sync_q[1];
            trig_q <= trig_d;
            cnt_q  <= cnt_d;
            tmr_q  <= tmr_d;
            res_q  <= res_d;
            done_q <= done_d;
            to_q   <= to_d;
        end
    end

    assign trig_o    = trig_q;
    assign done_o    = done_q;
    assign timeout_o = to_q;
    assign result_o  = res_q;

endmodule

// File: rtl/io_pulse_capture.sv
// Memory-mapped multi-channel trigger/echo-width capture: address decode, read mux, hit flag.
// Optional per-channel timeout is enabled by defining IO_CAPTURE_TIMEOUT_EN.
module io_pulse_capture
    import io_capture_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned TRIG_CYC    = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter logic [11:0] BASE_ADDR   = 12'hF00
) (
    input  logic              CLK,
    input  logic              CPU_RESETN,
    input  logic [NUM_CH-1:0] pins_in,
    output logic [NUM_CH-1:0] trig_out,
    input  logic [11:0]       addr,
    input  logic              wEn,
    input  logic [31:0]       dataIn,
    output logic [31:0]       dataOut,
    output logic              hit
);

    logic              in_win, ctrl_wr, rd_en;
    logic [11:0]       off;
    logic [NUM_CH-1:0] done, tmo_flag;
    logic [CNT_W-1:0]  result [NUM_CH];
    logic [31:0]       status, rdata_d, rdata_q;
    logic              hit_q;
    logic              unused_data_in;

    // Widen by one bit so a window near the top of the address space cannot wrap.
    assign in_win  = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, addr} <= {1'b0, BASE_ADDR} + 13'(NUM_CH));
    assign off     = addr - BASE_ADDR;
    assign ctrl_wr = in_win && wEn && (off == 12'(OffCtrl));
    assign rd_en   = in_win && !wEn;

    assign unused_data_in = ^dataIn[31:NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        capture_channel #(
            .CNT_W       (CNT_W),
            .TRIG_CYC    (TRIG_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk_i     (CLK),
            .rst_ni    (CPU_RESETN),
            .pin_i     (pins_in[g]),
            .start_i   (ctrl_wr && dataIn[g]),
            .rd_clr_i  (rd_en && (off == 12'(OffResult0 + g))),
            .trig_o    (trig_out[g]),
            .done_o    (done[g]),
            .timeout_o (tmo_flag[g]),
            .result_o  (result[g])
        );
    end

    always_comb begin
        status = '0;
        status[StatusDoneLsb +: NUM_CH] = done;
        status[StatusToLsb +: NUM_CH]   = tmo_flag;
    end

    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            if (off == 12'(OffCtrl)) rdata_d = status;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (off == 12'(OffResult0 + i)) rdata_d = 32'(result[i]);
            end
        end
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            hit_q   <= in_win;
        end
    end

    assign dataOut = rdata_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_io_pulse_capture.sv
// Directed bench for io_pulse_capture: a 24-bit-counter instance and an 8-bit one share the bus.
module tb_io_pulse_capture;

    localparam logic [11:0] Base = 12'hF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pins = '0;
    logic [11:0] addr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [7:0]  trig, trig8;
    logic [31:0] rdata, rdata8;
    logic        hit, hit8;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_pulse_capture #(
        .NUM_CH(8), .CNT_W(24), .TRIG_CYC(10), .TIMEOUT_CYC(1000), .BASE_ADDR(Base)
    ) dut (
        .CLK(clk), .CPU_RESETN(rst_n), .pins_in(pins), .trig_out(trig),
        .addr(addr), .wEn(wen), .dataIn(wdata), .dataOut(rdata), .hit(hit)
    );

    io_pulse_capture #(
        .NUM_CH(8), .CNT_W(8), .TRIG_CYC(10), .TIMEOUT_CYC(1000), .BASE_ADDR(Base)
    ) dut8 (
        .CLK(clk), .CPU_RESETN(rst_n), .pins_in(pins), .trig_out(trig8),
        .addr(addr), .wEn(wen), .dataIn(wdata), .dataOut(rdata8), .hit(hit8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wen = 1'b1; wdata = d;
        @(negedge clk);
        addr = '0; wen = 1'b0; wdata = '0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d8,
                          output logic h);
        @(negedge clk);
        addr = a; wen = 1'b0;
        @(negedge clk);
        d = rdata; d8 = rdata8; h = hit;
        addr = '0;
    endtask

    function automatic logic [31:0] in_range(input logic [31:0] v, input int lo, input int hi);
        return (v >= 32'(lo) && v <= 32'(hi)) ? 32'd1 : 32'd0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, d8;
        logic        h;
        int          tcnt;

        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'h0);
        check("rst_dout", rdata, 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        rst_n = 1'b1;

        // Basic: single channel, 500-cycle echo; 8-bit instance saturates.
        bus_wr(Base, 32'h1);
        tcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (trig[0]) tcnt++;
            else if (tcnt > 0) break;
            @(negedge clk);
        end
        check("trig_len", 32'(tcnt), 32'd10);
        repeat (20) @(negedge clk);
        pins[0] = 1'b1;
        repeat (500) @(negedge clk);
        pins[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(Base, d, d8, h);
        check("basic_status", d, 32'h1);
        check("basic_hit", 32'(h), 32'h1);
        bus_rd(Base, d, d8, h);
        check("basic_status_again", d, 32'h1);
        check("sat_status", d8, 32'h1);
        bus_rd(Base + 12'd1, d, d8, h);
        check("basic_res0_range", in_range(d, 499, 501), 32'd1);
        check("sat_res0", d8, 32'd255);
        bus_rd(Base, d, d8, h);
        check("basic_status_clr", d, 32'h0);
        check("sat_status_clr", d8, 32'h0);

        // Multi-start of channels 0 and 7.
        bus_wr(Base, 32'h81);
        repeat (15) @(negedge clk);
        pins = 8'h81;
        repeat (100) @(negedge clk);
        pins[0] = 1'b0;
        repeat (200) @(negedge clk);
        pins[7] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(Base, d, d8, h);
        check("multi_status", d, 32'h81);
        bus_rd(Base + 12'd1, d, d8, h);
        check("multi_res0_range", in_range(d, 99, 101), 32'd1);
        check("multi_res0_8b", in_range(d8, 99, 101), 32'd1);
        bus_rd(Base + 12'd8, d, d8, h);
        check("multi_res7_range", in_range(d, 299, 301), 32'd1);
        check("multi_res7_sat", d8, 32'd255);
        bus_rd(Base, d, d8, h);
        check("multi_status_clr", d, 32'h0);

        // A start written while measuring must not restart the channel.
        bus_wr(Base, 32'h2);
        repeat (15) @(negedge clk);
        pins[1] = 1'b1;
        repeat (50) @(negedge clk);
        bus_wr(Base, 32'h2);
        check("busy_no_trig", 32'(trig[1]), 32'h0);
        repeat (48) @(negedge clk);
        pins[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(Base, d, d8, h);
        check("busy_status", d, 32'h2);
        bus_rd(Base + 12'd2, d, d8, h);
        check("busy_res1_range", in_range(d, 99, 101), 32'd1);

        // hit decode and its one-cycle latency.
        bus_rd(Base + 12'd9, d, d8, h);
        check("oow_hit", 32'(h), 32'h0);
        check("oow_data", d, 32'h0);
        check("oow_hit8", 32'(hit8), 32'h0);
        @(negedge clk);
        addr = Base;
        check("hit_before", 32'(hit), 32'h0);
        @(negedge clk);
        addr = '0;
        check("hit_after1", 32'(hit), 32'h1);
        @(negedge clk);
        check("hit_drop", 32'(hit), 32'h0);

        // No echo on channel 3.
        bus_wr(Base, 32'h8);
        repeat (1100) @(negedge clk);
`ifdef IO_CAPTURE_TIMEOUT_EN
        bus_rd(Base, d, d8, h);
        check("tmo_status", d, 32'h0008_0008);
        bus_rd(Base + 12'd4, d, d8, h);
        check("tmo_res3", d, 32'h0);
`else
        bus_rd(Base, d, d8, h);
        check("notmo_status", d, 32'h0);
        check("notmo_trig", 32'(trig), 32'h0);
        pins[3] = 1'b1;
        repeat (50) @(negedge clk);
        pins[3] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(Base, d, d8, h);
        check("late_echo_status", d, 32'h8);
        bus_rd(Base + 12'd4, d, d8, h);
        check("late_echo_res3", in_range(d, 49, 51), 32'd1);
`endif

        // Asynchronous reset mid-measure on channel 2 while channel 5 triggers.
        bus_wr(Base, 32'h4);
        repeat (15) @(negedge clk);
        pins[2] = 1'b1;
        repeat (30) @(negedge clk);
        bus_wr(Base, 32'h20);
        check("pre_rst_trig5", 32'(trig[5]), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_trig", 32'(trig), 32'h0);
        check("async_rst_trig8", 32'(trig8), 32'h0);
        check("async_rst_dout", rdata, 32'h0);
        repeat (3) @(negedge clk);
        pins = '0;
        rst_n = 1'b1;
        bus_rd(Base, d, d8, h);
        check("post_rst_status", d, 32'h0);
        bus_rd(Base + 12'd3, d, d8, h);
        check("post_rst_res2", d, 32'h0);
        bus_rd(Base + 12'd1, d, d8, h);
        check("post_rst_res0", d, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
